timer_compare_unit: RTL and testbench
=====================================

# timer_compare_unit

Output-compare/PWM companion to the timer capture core: where the capture core latches the timer on an external trigger, this block drives an external waveform from an internal prescaled up-counter matched against a programmable compare value. It uses the same add/t_data/wen/ren register port style, so firmware and benches drive both blocks alike. It raises a one-cycle match strobe for the interrupt controller.

## Interface
- No parameters; all data widths are fixed at 32 bits.
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge.
- wen  in  1  write strobe; writes t_data to the register selected by add.
- ren  in  1  read strobe; reads the register selected by add.
- add  in  2  register select:
  - 00 prescaler
  - 01 control
  - 10 period
  - 11 compare
- t_data  in  32  write data.
- out_sel  in  2  output action, sampled every cycle:
  - 00 toggle on match
  - 01 set at wrap, clear on match (PWM)
  - 10 clear at wrap, set on match (inverted PWM)
  - 11 one-cycle pulse on match
- r_data  out  32  read data; registered.
- data_ready  out  1  one-cycle pulse when r_data is valid.
- cmp_out  out  1  compare output pin.
- match_irq  out  1  one-cycle pulse per match event.
- cnt_val  out  32  live counter value.

## Operation
- Control register bits:
  - bit0 enable.
  - bit1 one_shot.
  - bit2 clear: write-only, self-clearing; forces cnt and the prescaler counter to 0 on the next edge.
  - Other bits read as 0.
- Prescaler: pc counts 0..prescaler. A tick occurs in any enabled cycle where pc==prescaler; pc then returns to 0. prescaler=0 gives a tick every enabled cycle.
- Counter: on each tick, cnt increments. A wrap event is a tick with cnt==period; cnt then loads 0. The period is period+1 ticks.
- Match event: a tick with cnt==compare_active. If compare>period, no match ever occurs.
- Match and wrap on the same tick (compare==period): the wrap action wins in modes 01/10; the toggle/pulse still occurs in modes 00/11. match_irq pulses in all modes.
- Period and compare are shadowed:
  - While enabled, a write goes to the shadow only; the shadow copies to the active register on the wrap edge.
  - While disabled, a write updates shadow and active together.
  - Reads return the shadow.
- Enable 0->1 starts counting from the current cnt (0 after reset or clear). Writing enable=1 while already enabled does not restart the counter.
- Disable holds cnt and cmp_out, and clears pc.
- one_shot=1: on the first wrap, cnt loads 0, the wrap output action is applied, and enable self-clears.
- Same-cycle ren and wen to the same address: r_data returns the pre-write value.
- Reset values: all registers, pc, cnt, r_data, data_ready, cmp_out, match_irq, cnt_val = 0.

## Timing
- Register write: the value is visible to the logic on the edge after wen.
- Read: r_data and data_ready are valid one cycle after the ren cycle. data_ready pulses for one cycle per ren cycle. Holding ren high gives back-to-back reads.
- Tick/match/wrap: cnt, cmp_out and match_irq update on the edge that ends the tick cycle. There is no extra output latency.
- Pulse mode (11): cmp_out is high for exactly the one cycle after the matching edge.
- reset asserted mid-operation overrides wen/ren/ticks in the same cycle. Outputs are 0 on the following cycle.

## Test plan
- Reset behaviour:
  - Stimulus: hold reset 5 cycles mid-run with out_sel=01.
  - Required: cmp_out=0, cnt_val=0, data_ready=0, match_irq=0 the cycle after reset.
  - Required: a control readback returns 0.
- PWM duty:
  - Stimulus: prescaler=0, period=9, compare=3, out_sel=01, enable.
  - Required: cmp_out high 4 cycles, low 6, repeating.
  - Required: match_irq pulses once per 10 cycles.
- Prescaler and toggle:
  - Stimulus: prescaler=1, period=4, compare=2, out_sel=00.
  - Required: a tick every 2 cycles.
  - Required: cmp_out toggles every 10 cycles.
- Shadow load:
  - Stimulus: while running period=9, write compare=7 when cnt=2.
  - Required: compare=3 stays in effect until the wrap.
  - Required: the next period is high for 8 cycles.
  - Required: a readback returns 7 immediately.
- One-shot and edge cases:
  - Stimulus: one_shot=1, period=5, compare=5, out_sel=01.
  - Required: wrap wins, so cmp_out=1 after the wrap.
  - Required: enable reads 0 and cnt_val holds 0.
  - Stimulus: compare=20 with period=5.
  - Required: no match_irq.
- Read/write collision:
  - Stimulus: ren and wen to add=10 in the same cycle, old=9, new=15.
  - Required: r_data=9 with data_ready the next cycle.
  - Required: a following read returns 15.

Source files
------------

// File: rtl/timer_compare_unit.sv
// Output-compare / PWM unit: a prescaled up-counter matched against a shadowed
// compare value drives cmp_out and raises a one-cycle match_irq per match event.
module timer_compare_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        wen,
    input  logic        ren,
    input  logic [1:0]  add,
    input  logic [31:0] t_data,
    input  logic [1:0]  out_sel,
    output logic [31:0] r_data,
    output logic        data_ready,
    output logic        cmp_out,
    output logic        match_irq,
    output logic [31:0] cnt_val
);

    localparam logic [1:0] ADDR_PRESC  = 2'b00;
    localparam logic [1:0] ADDR_CTRL   = 2'b01;
    localparam logic [1:0] ADDR_PERIOD = 2'b10;
    localparam logic [1:0] ADDR_CMP    = 2'b11;

    logic [31:0] prescaler;
    logic [31:0] period_sh;
    logic [31:0] period_act;
    logic [31:0] compare_sh;
    logic [31:0] compare_act;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        enable;
    logic        one_shot;

    logic        tick;
    logic        wrap;
    logic        match;
    logic        wr_presc;
    logic        wr_ctrl;
    logic        wr_period;
    logic        wr_cmp;
    logic        clear;
    logic [31:0] rd_mux;

    // Wrap takes priority over match in the PWM modes so compare==period
    // leaves the pin in its wrap level.
    function automatic logic next_cmp_out(input logic [1:0] mode, input logic cur,
                                          input logic wrap_ev, input logic match_ev);
        logic nxt;
        nxt = cur;
        case (mode)
            2'b00: if (match_ev) nxt = ~cur;
            2'b01: begin
                if (wrap_ev)       nxt = 1'b1;
                else if (match_ev) nxt = 1'b0;
            end
            2'b10: begin
                if (wrap_ev)       nxt = 1'b0;
                else if (match_ev) nxt = 1'b1;
            end
            default: nxt = match_ev;
        endcase
        return nxt;
    endfunction

    assign tick      = enable && (pc == prescaler);
    assign wrap      = tick && (cnt == period_act);
    assign match     = tick && (cnt == compare_act);
    assign wr_presc  = wen && (add == ADDR_PRESC);
    assign wr_ctrl   = wen && (add == ADDR_CTRL);
    assign wr_period = wen && (add == ADDR_PERIOD);
    assign wr_cmp    = wen && (add == ADDR_CMP);
    assign clear     = wr_ctrl && t_data[2];
    assign cnt_val   = cnt;

    always_comb begin
        rd_mux = 32'd0;
        case (add)
            ADDR_PRESC:  rd_mux = prescaler;
            ADDR_CTRL:   rd_mux = {30'd0, one_shot, enable};
            ADDR_PERIOD: rd_mux = period_sh;
            default:     rd_mux = compare_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler   <= 32'd0;
            period_sh   <= 32'd0;
            period_act  <= 32'd0;
            compare_sh  <= 32'd0;
            compare_act <= 32'd0;
            pc          <= 32'd0;
            cnt         <= 32'd0;
            enable      <= 1'b0;
            one_shot    <= 1'b0;
            r_data      <= 32'd0;
            data_ready  <= 1'b0;
            cmp_out     <= 1'b0;
            match_irq   <= 1'b0;
        end else begin
            data_ready <= ren;
            if (ren) r_data <= rd_mux;

            match_irq <= match;
            cmp_out   <= next_cmp_out(out_sel, cmp_out, wrap, match);

            if (clear) begin
                pc  <= 32'd0;
                cnt <= 32'd0;
            end else begin
                pc <= (!enable || tick) ? 32'd0 : pc + 32'd1;
                if (tick) cnt <= wrap ? 32'd0 : cnt + 32'd1;
            end

            // Shadow copy happens before this cycle's write lands in the shadow.
            if (wrap) begin
                period_act  <= period_sh;
                compare_act <= compare_sh;
            end
            if (wr_presc) prescaler <= t_data;
            if (wr_period) begin
                period_sh <= t_data;
                if (!enable) period_act <= t_data;
            end
            if (wr_cmp) begin
                compare_sh <= t_data;
                if (!enable) compare_act <= t_data;
            end

            if (wrap && one_shot) enable <= 1'b0;
            if (wr_ctrl) begin
                enable   <= t_data[0];
                one_shot <= t_data[1];
            end
        end
    end

endmodule

// File: tb/tb_timer_compare_unit.sv
// Bench for timer_compare_unit: directed test-plan scenarios plus random traffic,
// with a queue-based scoreboard fed by a cycle reference model.
module tb_timer_compare_unit;

    logic        clk;
    logic        reset;
    logic        wen;
    logic        ren;
    logic [1:0]  add;
    logic [31:0] t_data;
    logic [1:0]  out_sel;
    logic [31:0] r_data;
    logic        data_ready;
    logic        cmp_out;
    logic        match_irq;
    logic [31:0] cnt_val;

    int n_tests = 0;
    int n_fail  = 0;

    timer_compare_unit dut (
        .clk(clk), .reset(reset), .wen(wen), .ren(ren), .add(add),
        .t_data(t_data), .out_sel(out_sel), .r_data(r_data),
        .data_ready(data_ready), .cmp_out(cmp_out), .match_irq(match_irq),
        .cnt_val(cnt_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        co;
        logic        irq;
        logic        dr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the timer described as events (tick, wrap, match) on
    // integer state, advanced once per rising edge.
    logic [31:0] m_presc, m_per_sh, m_per_a, m_cmp_sh, m_cmp_a, m_pc, m_cnt;
    logic        m_en, m_os, m_out, m_irq, m_dr;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_presc;
            2'd1:    return {30'd0, m_os, m_en};
            2'd2:    return m_per_sh;
            default: return m_cmp_sh;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic tk, wrap_ev, match_ev, was_en;
        exp_t e;
        if (reset) begin
            m_presc = 0; m_per_sh = 0; m_per_a = 0; m_cmp_sh = 0; m_cmp_a = 0;
            m_pc = 0; m_cnt = 0; m_en = 0; m_os = 0; m_out = 0; m_irq = 0; m_dr = 0;
        end else begin
            was_en   = m_en;
            tk       = m_en && (m_pc == m_presc);
            wrap_ev  = tk && (m_cnt == m_per_a);
            match_ev = tk && (m_cnt == m_cmp_a);
            if (ren) rd_q.push_back(m_read(add));
            m_dr  = ren;
            m_irq = match_ev;
            case (out_sel)
                2'd0: if (match_ev) m_out = !m_out;
                2'd1: m_out = wrap_ev ? 1'b1 : (match_ev ? 1'b0 : m_out);
                2'd2: m_out = wrap_ev ? 1'b0 : (match_ev ? 1'b1 : m_out);
                default: m_out = match_ev;
            endcase
            if (!m_en) m_pc = 0;
            else if (tk) m_pc = 0;
            else m_pc = m_pc + 1;
            if (wrap_ev) m_cnt = 0;
            else if (tk) m_cnt = m_cnt + 1;
            if (wrap_ev) begin
                m_per_a = m_per_sh;
                m_cmp_a = m_cmp_sh;
                if (m_os) m_en = 0;
            end
            if (wen) begin
                case (add)
                    2'd0: m_presc = t_data;
                    2'd1: begin
                        m_en = t_data[0];
                        m_os = t_data[1];
                        if (t_data[2]) begin m_cnt = 0; m_pc = 0; end
                    end
                    2'd2: begin m_per_sh = t_data; if (!was_en) m_per_a = t_data; end
                    default: begin m_cmp_sh = t_data; if (!was_en) m_cmp_a = t_data; end
                endcase
            end
        end
        e.co = m_out; e.irq = m_irq; e.dr = m_dr; e.cnt = m_cnt;
        exp_q.push_back(e);
    end

    // Monitor: compares every cycle's outputs and every read response.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [31:0] rv;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cmp_out", {31'd0, cmp_out}, {31'd0, e.co});
            chk("match_irq", {31'd0, match_irq}, {31'd0, e.irq});
            chk("data_ready", {31'd0, data_ready}, {31'd0, e.dr});
            chk("cnt_val", cnt_val, e.cnt);
            if (data_ready === 1'b1) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    rv = rd_q.pop_front();
                    chk("r_data", r_data, rv);
                end
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        add = a; t_data = d; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        add = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        chk("rd_ready", {31'd0, data_ready}, 32'd1);
        v = r_data;
    endtask

    task automatic rw(input logic [1:0] a, input logic [31:0] d, output logic [31:0] v);
        add = a; t_data = d; ren = 1'b1; wen = 1'b1;
        @(negedge clk);
        ren = 1'b0; wen = 1'b0;
        chk("rw_ready", {31'd0, data_ready}, 32'd1);
        v = r_data;
    endtask

    task automatic wait_cnt(input logic [31:0] target);
        int n = 0;
        while (cnt_val !== target && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cnt", cnt_val, target);
    endtask

    initial begin : driver
        logic [31:0] v;
        logic        prev_o;
        logic [31:0] prev_c;
        int          hi, irqs, chg, n;

        reset = 1'b1; wen = 1'b0; ren = 1'b0; add = 2'd0; t_data = 32'd0; out_sel = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_cmp_out", {31'd0, cmp_out}, 32'd0);
        chk("rst_cnt_val", cnt_val, 32'd0);

        // PWM duty: 4 high / 6 low, one irq per 10 cycles
        wr(2'd0, 32'd0); wr(2'd2, 32'd9); wr(2'd3, 32'd3);
        out_sel = 2'd1;
        wr(2'd1, 32'd1);
        repeat (12) @(negedge clk);
        hi = 0; irqs = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmp_out === 1'b1) hi++;
            if (match_irq === 1'b1) irqs++;
            @(negedge clk);
        end
        chk("pwm_high_cycles", hi, 32'd8);
        chk("pwm_irq_count", irqs, 32'd2);

        // Reset held 5 cycles mid-run
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        chk("midrst_cmp_out", {31'd0, cmp_out}, 32'd0);
        chk("midrst_cnt_val", cnt_val, 32'd0);
        chk("midrst_ready", {31'd0, data_ready}, 32'd0);
        chk("midrst_irq", {31'd0, match_irq}, 32'd0);
        rd(2'd1, v);
        chk("midrst_ctrl", v, 32'd0);

        // Prescaler=1 and toggle mode
        wr(2'd0, 32'd1); wr(2'd2, 32'd4); wr(2'd3, 32'd2);
        out_sel = 2'd0;
        wr(2'd1, 32'd1);
        repeat (3) @(negedge clk);
        chg = 0; prev_c = cnt_val;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cnt_val !== prev_c) chg++;
            prev_c = cnt_val;
        end
        chk("presc_ticks", chg, 32'd10);
        chg = 0; prev_o = cmp_out;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmp_out !== prev_o) chg++;
            prev_o = cmp_out;
        end
        chk("toggle_count", chg, 32'd4);

        // Shadow load of compare while running
        wr(2'd1, 32'd0); wr(2'd1, 32'd4);
        wr(2'd0, 32'd0); wr(2'd2, 32'd9); wr(2'd3, 32'd3);
        out_sel = 2'd1;
        wr(2'd1, 32'd1);
        wait_cnt(32'd2);
        wr(2'd3, 32'd7);
        rd(2'd3, v);
        chk("shadow_readback", v, 32'd7);
        wait_cnt(32'd5);
        chk("shadow_old_cmp", {31'd0, cmp_out}, 32'd0);
        n = 0;
        while (cmp_out !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        hi = 0;
        while (cmp_out === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
        chk("shadow_high_cycles", hi, 32'd8);

        // One-shot with compare==period: wrap wins
        wr(2'd1, 32'd0); wr(2'd1, 32'd4);
        wr(2'd2, 32'd5); wr(2'd3, 32'd5);
        out_sel = 2'd1;
        wr(2'd1, 32'd3);
        repeat (10) @(negedge clk);
        chk("oneshot_cmp_out", {31'd0, cmp_out}, 32'd1);
        chk("oneshot_cnt", cnt_val, 32'd0);
        rd(2'd1, v);
        chk("oneshot_enable", {31'd0, v[0]}, 32'd0);

        // compare beyond period never matches
        wr(2'd3, 32'd20);
        wr(2'd1, 32'd1);
        irqs = 0;
        for (int i = 0; i < 30; i++) begin
            if (match_irq === 1'b1) irqs++;
            @(negedge clk);
        end
        chk("no_match_irq", irqs, 32'd0);

        // Same-cycle read and write of period
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd9);
        rw(2'd2, 32'd15, v);
        chk("collide_old", v, 32'd9);
        rd(2'd2, v);
        chk("collide_new", v, 32'd15);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            wen   = ($urandom_range(0, 5) == 0);
            ren   = ($urandom_range(0, 3) == 0);
            add   = 2'($urandom_range(0, 3));
            case (add)
                2'd0:    t_data = $urandom_range(0, 2);
                2'd1:    t_data = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 32'd1;
                2'd2:    t_data = $urandom_range(0, 7);
                default: t_data = $urandom_range(0, 9);
            endcase
            if ($urandom_range(0, 19) == 0) out_sel = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        reset = 1'b0; wen = 1'b0; ren = 1'b0;
        repeat (3) @(negedge clk);
        chk("rd_q_drained", rd_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
